// File: rtl/regfile_scoreboard.sv
// Three-read / one-write register file with registered outputs, write bypass,
// optional hardwired zero register and a per-register pending (scoreboard) bit.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic [ADDR_W-1:0] read_reg3,
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2,
  output logic [DATA_W-1:0] data_out3,
  output logic              pend_out1,
  output logic              pend_out2,
  output logic              pend_out3,
  input  logic              EnableWrite,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              pend_set,
  input  logic [ADDR_W-1:0] pend_reg
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pend;

  logic              wr_ok;
  logic              set_ok;
  logic [ADDR_W-1:0] raddr    [3];
  logic [DATA_W-1:0] rd_data  [3];
  logic              rd_pend  [3];
  logic [DATA_W-1:0] data_q   [3];
  logic              pend_q   [3];

  // Accesses to register 0 are squashed here so storage, pending and bypass
  // all see the same filtered strobes.
  always_comb begin
    wr_ok  = EnableWrite && !(ZERO_REG && (write_reg == '0));
    set_ok = pend_set    && !(ZERO_REG && (pend_reg  == '0));
  end

  assign raddr[0] = read_reg1;
  assign raddr[1] = read_reg2;
  assign raddr[2] = read_reg3;

  // Read values reflect this cycle's updates; a set beats a clear.
  always_comb begin
    for (int unsigned p = 0; p < 3; p++) begin
      rd_data[p] = mem[raddr[p]];
      rd_pend[p] = pend[raddr[p]];
      if (wr_ok && (write_reg == raddr[p])) begin
        rd_data[p] = write_data;
        rd_pend[p] = 1'b0;
      end
      if (set_ok && (pend_reg == raddr[p])) begin
        rd_pend[p] = 1'b1;
      end
      if (ZERO_REG && (raddr[p] == '0)) begin
        rd_data[p] = '0;
        rd_pend[p] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem  <= '{default: '0};
      pend <= '0;
    end else begin
      if (wr_ok) begin
        mem[write_reg]  <= write_data;
        pend[write_reg] <= 1'b0;
      end
      if (set_ok) begin
        pend[pend_reg] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '{default: '0};
      pend_q <= '{default: 1'b0};
    end else if (rd_en) begin
      data_q <= rd_data;
      pend_q <= rd_pend;
    end
  end

  assign data_out1 = data_q[0];
  assign data_out2 = data_q[1];
  assign data_out3 = data_q[2];
  assign pend_out1 = pend_q[0];
  assign pend_out2 = pend_q[1];
  assign pend_out3 = pend_q[2];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: one ZERO_REG=1 and one ZERO_REG=0
// instance share the same stimulus.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst, rd_en, EnableWrite, pend_set;
  logic [4:0]  read_reg1, read_reg2, read_reg3, write_reg, pend_reg;
  logic [31:0] write_data;
  logic [31:0] data_out1, data_out2, data_out3;
  logic        pend_out1, pend_out2, pend_out3;
  logic [31:0] z0_data1, z0_data2, z0_data3;
  logic        z0_pend1, z0_pend2, z0_pend3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en),
    .read_reg1(read_reg1), .read_reg2(read_reg2), .read_reg3(read_reg3),
    .data_out1(data_out1), .data_out2(data_out2), .data_out3(data_out3),
    .pend_out1(pend_out1), .pend_out2(pend_out2), .pend_out3(pend_out3),
    .EnableWrite(EnableWrite), .write_reg(write_reg), .write_data(write_data),
    .pend_set(pend_set), .pend_reg(pend_reg)
  );

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b0)) dut0 (
    .clk(clk), .rst(rst), .rd_en(rd_en),
    .read_reg1(read_reg1), .read_reg2(read_reg2), .read_reg3(read_reg3),
    .data_out1(z0_data1), .data_out2(z0_data2), .data_out3(z0_data3),
    .pend_out1(z0_pend1), .pend_out2(z0_pend2), .pend_out3(z0_pend3),
    .EnableWrite(EnableWrite), .write_reg(write_reg), .write_data(write_data),
    .pend_set(pend_set), .pend_reg(pend_reg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    EnableWrite = 1'b0;
    pend_set    = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3);
    rd_en = 1'b1;
    read_reg1 = a1;
    read_reg2 = a2;
    read_reg3 = a3;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    EnableWrite = 1'b1;
    write_reg   = a;
    write_data  = d;
  endtask

  task automatic ps(input logic [4:0] a);
    pend_set = 1'b1;
    pend_reg = a;
  endtask

  initial begin
    rst = 1'b1; rd_en = 1'b0; idle();
    read_reg1 = '0; read_reg2 = '0; read_reg3 = '0;
    write_reg = '0; write_data = '0; pend_reg = '0;
    #1;
    tick(); tick();
    chk("reset_data1", data_out1, 32'h0);
    chk("reset_pend1", {31'b0, pend_out1}, 32'h0);

    rst = 1'b0;
    rd(5'd3, 5'd7, 5'd31);
    tick();
    chk("rd0_data1", data_out1, 32'h0);
    chk("rd0_data2", data_out2, 32'h0);
    chk("rd0_data3", data_out3, 32'h0);
    chk("rd0_pend", {29'b0, pend_out1, pend_out2, pend_out3}, 32'h0);

    // write reg 9 with reads disabled; outputs must hold
    rd_en = 1'b0; wr(5'd9, 32'hDEADBEEF); read_reg1 = 5'd9;
    tick();
    chk("hold_during_write", data_out1, 32'h0);
    idle(); rd(5'd9, 5'd9, 5'd9);
    tick();
    chk("readback9", data_out1, 32'hDEADBEEF);
    rd_en = 1'b0; read_reg1 = 5'd3;
    tick();
    chk("hold_rd_en_low", data_out1, 32'hDEADBEEF);

    // same-cycle bypass on all ports
    wr(5'd20, 32'h12345678); rd(5'd20, 5'd20, 5'd20);
    tick();
    chk("bypass1", data_out1, 32'h12345678);
    chk("bypass2", data_out2, 32'h12345678);
    chk("bypass3", data_out3, 32'h12345678);

    // zero register: bypass cycle and later read
    wr(5'd0, 32'hFFFFFFFF); ps(5'd0); rd(5'd0, 5'd0, 5'd0);
    tick();
    chk("zero_byp_data", data_out1, 32'h0);
    chk("zero_byp_pend", {31'b0, pend_out2}, 32'h0);
    chk("nozero_byp_data", z0_data1, 32'hFFFFFFFF);
    chk("nozero_byp_pend", {31'b0, z0_pend3}, 32'h1);
    idle();
    tick();
    chk("zero_data", data_out3, 32'h0);
    chk("zero_pend", {31'b0, pend_out1}, 32'h0);
    chk("nozero_data", z0_data2, 32'hFFFFFFFF);

    // scoreboard sequence on reg 5
    ps(5'd5); rd(5'd5, 5'd5, 5'd5);
    tick();
    chk("set_same_cycle", {31'b0, pend_out1}, 32'h1);
    idle();
    tick();
    chk("set_later", {31'b0, pend_out2}, 32'h1);
    chk("set_later_data", data_out2, 32'h0);
    wr(5'd5, 32'h55);
    tick();
    chk("clear_pend", {31'b0, pend_out1}, 32'h0);
    chk("clear_data", data_out1, 32'h55);
    wr(5'd5, 32'hAA); ps(5'd5);
    tick();
    chk("set_wins_pend", {31'b0, pend_out3}, 32'h1);
    chk("set_wins_data", data_out3, 32'hAA);
    idle();
    tick();
    chk("set_wins_later", {31'b0, pend_out1}, 32'h1);

    // independent ports
    rd(5'd9, 5'd20, 5'd5);
    tick();
    chk("indep1", data_out1, 32'hDEADBEEF);
    chk("indep2", data_out2, 32'h12345678);
    chk("indep3", data_out3, 32'hAA);
    chk("indep_pend", {29'b0, pend_out1, pend_out2, pend_out3}, 32'h1);

    // mid-stream reset with regs 4 and 6 pending and holding data
    rd_en = 1'b0;
    wr(5'd4, 32'h44);
    tick();
    wr(5'd6, 32'h66); ps(5'd4);
    tick();
    idle(); ps(5'd6);
    tick();
    idle(); rd(5'd4, 5'd6, 5'd6);
    tick();
    chk("pre_rst_data4", data_out1, 32'h44);
    chk("pre_rst_pend", {30'b0, pend_out1, pend_out2}, 32'h3);
    rst = 1'b1; wr(5'd4, 32'h99); ps(5'd6);
    tick();
    chk("rst_out_data", data_out2, 32'h0);
    chk("rst_out_pend", {31'b0, pend_out1}, 32'h0);
    rst = 1'b0; idle();
    tick();
    chk("post_rst_data4", data_out1, 32'h0);
    chk("post_rst_data6", data_out2, 32'h0);
    chk("post_rst_pend", {30'b0, pend_out1, pend_out2}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised successor to the processor's 3-read/1-write integer register file. It adds synchronous reset, registered read outputs with write-to-read bypass, a hardwired zero register and a per-register pending (scoreboard) bit. The decode stage uses the pending bits to stall on RAW hazards, and writeback clears them. It sits between the decode stage (reads, pending set) and writeback (writes).

## Interface
- DATA_W, 32: register width in bits.
- ADDR_W, 5: address width; depth = 2**ADDR_W.
- ZERO_REG, 1: 1 = register 0 reads as 0, ignores writes and never goes pending; 0 = register 0 is ordinary.
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- rd_en  in  1  capture new read results this cycle.
- read_reg1, read_reg2, read_reg3  in  ADDR_W each  read addresses.
- data_out1, data_out2, data_out3  out  DATA_W each  registered read data.
- pend_out1, pend_out2, pend_out3  out  1 each  registered pending bit of the corresponding read address.
- EnableWrite  in  1  writeback write strobe.
- write_reg  in  ADDR_W  write address.
- write_data  in  DATA_W  write data.
- pend_set  in  1  mark pend_reg as awaiting a result (issued instruction).
- pend_reg  in  ADDR_W  destination register to mark pending.

## Operation
- Storage: 2**ADDR_W words of DATA_W bits, plus 2**ADDR_W pending bits.
- Write: on posedge, if EnableWrite, mem[write_reg] <= write_data and pend[write_reg] <= 0.
- Pending set: on posedge, if pend_set, pend[pend_reg] <= 1.
- Same-cycle write and pend_set to the same address: the data is written and the pending bit ends at 1 (set wins; the new producer is outstanding).
- Read: on posedge, if rd_en, each port n captures:
  - data_outn <= (EnableWrite && write_reg==read_regn) ? write_data : mem[read_regn] (write bypass).
  - pend_outn <= pend value after this cycle's updates, so the set/clear rules above apply in the bypass path too.
- rd_en low: all data_out and pend_out registers hold their values.
- ZERO_REG=1, address 0:
  - EnableWrite to address 0 is dropped.
  - pend_set to address 0 is dropped.
  - Reads of address 0 return 0 with pending 0, including the bypass path.
- Ports 1–3 are independent. Any duplicate read addresses return identical results.
- Reset (rst=1 at posedge):
  - All mem words <= 0, all pend bits <= 0.
  - data_out1..3 <= 0, pend_out1..3 <= 0.
  - Writes, pend_set and reads in that cycle are ignored.
  - Reset mid-stream discards any outstanding pending state.
- No other state machine: behaviour is fully determined by the current inputs and the stored arrays.

## Timing
- Read latency: 1 cycle. Addresses presented before posedge N appear on data_out/pend_out after posedge N.
- Write-to-read latency: 0 extra cycles (bypass). A read in the same cycle as the write returns the new data.
- Pending set visible to reads: a set in cycle N shows pend_out=1 for reads captured in cycle N (via the post-update rule) and in all later cycles until cleared.
- Pending clear follows the same rule: a write in cycle N makes pend_out=0 for reads captured in cycle N.
- Write-port throughput: one write and one pend_set per cycle.
- Outputs are registers only; there is no combinational path from inputs to outputs.
- Reset takes 1 cycle. All outputs are 0 from the first posedge with rst=1 until the first non-reset capture.

## Test plan
- Reset then read: rst=1 for 2 cycles, then read regs 3, 7, 31 with rd_en=1 -> all data_out=0 and pend_out=0 one cycle later.
- Write/readback: write 0xDEADBEEF to reg 9, then read reg 9 next cycle -> data_out1=0xDEADBEEF one cycle after the read. With rd_en=0, outputs hold the previous values.
- Bypass: in the same cycle, write 0x12345678 to reg 20 and read reg 20 on all three ports -> all data_out=0x12345678 after that posedge.
- Zero register (ZERO_REG=1): write 0xFFFFFFFF to reg 0 and pend_set reg 0 -> read of reg 0 returns 0 with pend 0 (also in the same-cycle bypass case). With ZERO_REG=0, the same sequence returns 0xFFFFFFFF.
- Scoreboard sequence:
  - pend_set reg 5 -> pend_out for reg 5 = 1.
  - Write 0x55 to reg 5 -> pend 0, data 0x55.
  - Write reg 5 and pend_set reg 5 in the same cycle -> data 0x55-new, pend 1.
- Mid-stream reset: with regs 4 and 6 pending and holding data, assert rst for one cycle -> next reads show data 0 and pend 0. A write issued in the reset cycle is not retained.
